// File: rtl/tcp_pkg.sv
// +----------------------------------------------------------------------------
// | tcp_pkg : shared types and constants for the TCP transmit path
// | Rev 1.0 : initial release
// +----------------------------------------------------------------------------
`default_nettype none

package tcp_pkg;

  typedef enum logic [2:0] {
    TX_CTRL_NONE         = 3'd0,
    TX_CTRL_SEND_SYN     = 3'd1,
    TX_CTRL_SEND_ACK     = 3'd2,
    TX_CTRL_SEND_SYN_ACK = 3'd3,
    TX_CTRL_SEND_FIN     = 3'd4,
    TX_CTRL_SEND_RST     = 3'd5,
    TX_CTRL_SEND_DATA    = 3'd6
  } tx_ctrl_t;

  localparam logic [7:0] FLAG_FIN = 8'h01;
  localparam logic [7:0] FLAG_SYN = 8'h02;
  localparam logic [7:0] FLAG_RST = 8'h04;
  localparam logic [7:0] FLAG_PSH = 8'h08;
  localparam logic [7:0] FLAG_ACK = 8'h10;
  localparam logic [7:0] FLAG_URG = 8'h20;
  localparam logic [7:0] FLAG_ECE = 8'h40;
  localparam logic [7:0] FLAG_CWR = 8'h80;

  // Queue entries carry the widest length any instance may use.
  localparam int c_REQ_LEN_W = 32;

  typedef struct packed {
    tx_ctrl_t                 ctrl;
    logic [c_REQ_LEN_W-1:0]   len;
  } tx_req_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } tx_state_t;

  // Zero flags marks an encoding that must be dropped.
  function automatic logic [7:0] tx_ctrl_flags(input tx_ctrl_t ctrl);
    case (ctrl)
      TX_CTRL_SEND_SYN:     return FLAG_SYN;
      TX_CTRL_SEND_SYN_ACK: return FLAG_SYN | FLAG_ACK;
      TX_CTRL_SEND_ACK:     return FLAG_ACK;
      TX_CTRL_SEND_FIN:     return FLAG_FIN | FLAG_ACK;
      TX_CTRL_SEND_RST:     return FLAG_RST | FLAG_ACK;
      TX_CTRL_SEND_DATA:    return FLAG_PSH | FLAG_ACK;
      default:              return 8'h00;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/tcp_tx_req_fifo.sv
// +----------------------------------------------------------------------------
// | tcp_tx_req_fifo : synchronous request FIFO with flush, head visible on o_rdata
// | Rev 1.0 : initial release
// +----------------------------------------------------------------------------
`default_nettype none

module tcp_tx_req_fifo
  import tcp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    i_clk,
  input  logic    i_rst,
  input  logic    i_flush,
  input  logic    i_push,
  input  tx_req_t i_wdata,
  input  logic    i_pop,
  output tx_req_t o_rdata,
  output logic    o_full,
  output logic    o_empty
);

  localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_AW:0] c_PTR_ONE = (c_AW + 1)'(1);

  tx_req_t         r_mem [DEPTH];
  logic [c_AW:0]   r_wr_ptr;
  logic [c_AW:0]   r_rd_ptr;
  logic            w_do_push;
  logic            w_do_pop;

  // Extra pointer MSB distinguishes full from empty.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
  assign w_do_push = i_push && !o_full && !i_flush;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_rdata   = r_mem[r_rd_ptr[c_AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[c_AW-1:0]] <= i_wdata;
  end

endmodule

`default_nettype wire

// File: rtl/tcp_tx_seq_ctrl.sv
// +----------------------------------------------------------------------------
// | tcp_tx_seq_ctrl : queued TCP transmit header controller owning SND.NXT
// | Optional TCP_TX_STATS_EN adds saturating segment/drop counters.
// | Rev 1.0 : initial release
// +----------------------------------------------------------------------------
`default_nettype none

module tcp_tx_seq_ctrl
  import tcp_pkg::*;
#(
  parameter logic [15:0] WINDOW_SIZE = 16'h1000,
  parameter logic [31:0] ISS         = 32'h0000_1000,
  parameter int          QUEUE_DEPTH = 4,
  parameter int          LEN_W       = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  tx_ctrl_t         i_tx_ctrl,
  input  logic [LEN_W-1:0] i_tx_len,
  input  logic             i_tx_ctrl_valid,
  output logic             o_tx_ctrl_ack,
  input  logic [31:0]      i_rcv_nxt,
  input  logic             i_iss_load,
  input  logic [31:0]      i_iss,
  input  logic             i_flush,
  output logic [31:0]      o_seq_number,
  output logic [31:0]      o_ack_number,
  output logic [7:0]       o_flags,
  output logic [15:0]      o_window_size,
  output logic [LEN_W-1:0] o_payload_len,
  output logic             o_hdr_valid,
  input  logic             i_packet_done,
  output logic [31:0]      o_snd_nxt,
`ifdef TCP_TX_STATS_EN
  output logic [15:0]      o_seg_count,
  output logic [7:0]       o_drop_count,
`endif
  output logic             o_busy
);

  tx_req_t          w_req;
  tx_req_t          w_head;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic             w_pop;
  logic [7:0]       w_head_flags;
  logic             w_head_legal;
  logic             w_head_is_data;
  logic [LEN_W-1:0] w_head_len;
  logic [31:0]      w_head_adv;
  logic             w_seg_done;

  tx_state_t        r_state;
  logic [31:0]      r_snd_nxt;
  logic [31:0]      r_adv;
  logic [31:0]      r_seq;
  logic [31:0]      r_ack;
  logic [7:0]       r_flags;
  logic [15:0]      r_window;
  logic [LEN_W-1:0] r_len;
  logic             r_hdr_valid;

  always_comb begin
    w_req      = '0;
    w_req.ctrl = i_tx_ctrl;
    w_req.len  = c_REQ_LEN_W'(i_tx_len);
  end

  tcp_tx_req_fifo #(
    .DEPTH   (QUEUE_DEPTH)
  ) u_req_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_flush (i_flush),
    .i_push  (i_tx_ctrl_valid),
    .i_wdata (w_req),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign w_pop          = (r_state == ST_IDLE) && !w_fifo_empty;
  assign w_head_flags   = tx_ctrl_flags(w_head.ctrl);
  assign w_head_legal   = (w_head_flags != 8'h00);
  assign w_head_is_data = (w_head.ctrl == TX_CTRL_SEND_DATA);
  assign w_head_len     = w_head_is_data ? w_head.len[LEN_W-1:0] : '0;
  // Sequence-space length is fixed at pop so completion needs only an add.
  assign w_head_adv     = (w_head_is_data ? w_head.len : 32'd0)
                        + {31'd0, w_head_flags[1]}
                        + {31'd0, w_head_flags[0]};
  assign w_seg_done     = (r_state == ST_SEND) && i_packet_done;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_adv       <= '0;
      r_seq       <= '0;
      r_ack       <= '0;
      r_flags     <= '0;
      r_window    <= '0;
      r_len       <= '0;
      r_hdr_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop && w_head_legal) begin
            r_seq       <= r_snd_nxt;
            r_ack       <= ((w_head_flags & FLAG_ACK) != 8'h00) ? i_rcv_nxt : 32'd0;
            r_flags     <= w_head_flags;
            r_window    <= WINDOW_SIZE;
            r_len       <= w_head_len;
            r_adv       <= w_head_adv;
            r_hdr_valid <= 1'b1;
            r_state     <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (i_packet_done) begin
            r_seq       <= '0;
            r_ack       <= '0;
            r_flags     <= '0;
            r_window    <= '0;
            r_len       <= '0;
            r_hdr_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // An ISS load wins over a completion in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst)           r_snd_nxt <= ISS;
    else if (i_iss_load) r_snd_nxt <= i_iss;
    else if (w_seg_done) r_snd_nxt <= r_snd_nxt + r_adv;
  end

  assign o_tx_ctrl_ack = !w_fifo_full;
  assign o_seq_number  = r_seq;
  assign o_ack_number  = r_ack;
  assign o_flags       = r_flags;
  assign o_window_size = r_window;
  assign o_payload_len = r_len;
  assign o_hdr_valid   = r_hdr_valid;
  assign o_snd_nxt     = r_snd_nxt;
  assign o_busy        = !w_fifo_empty || (r_state == ST_SEND);

`ifdef TCP_TX_STATS_EN
  logic [15:0] r_seg_count;
  logic [7:0]  r_drop_count;
  logic [1:0]  w_drop_evts;
  logic [7:0]  w_drop_inc;

  assign w_drop_evts = {1'b0, w_pop && !w_head_legal}
                     + {1'b0, i_tx_ctrl_valid && w_fifo_full};
  assign w_drop_inc  = {6'd0, w_drop_evts};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_seg_count  <= '0;
      r_drop_count <= '0;
    end else begin
      if (w_seg_done && (r_seg_count != 16'hFFFF))
        r_seg_count <= r_seg_count + 16'd1;
      if (r_drop_count > (8'hFF - w_drop_inc))
        r_drop_count <= 8'hFF;
      else
        r_drop_count <= r_drop_count + w_drop_inc;
    end
  end

  assign o_seg_count  = r_seg_count;
  assign o_drop_count = r_drop_count;
`endif

endmodule

`default_nettype wire

// File: doc/tcp_tx_seq_ctrl.md
Name: tcp_tx_seq_ctrl

Overview:
- Transmit header controller for the network processor's TCP engine.
- Accepts segment requests from the TCP state machine into a small request queue, then emits one header at a time: seq, ack, flags, window, payload length.
- Owns SND.NXT and advances it by the sequence-space length of each completed segment.
- Sits between the TCP connection FSM and the TCP header/packet builder.

Parameters:
- WINDOW_SIZE, 16'h1000, value driven on o_window_size for every segment.
- ISS, 32'h0000_1000, SND.NXT value after reset.
- QUEUE_DEPTH, 4, request FIFO entries; power of two, ≥2.
- LEN_W, 16, payload length width.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset; synchronous, active-high.
- i_tx_ctrl  in  tx_ctrl_t  requested segment type.
- i_tx_len  in  LEN_W  payload bytes; used only for TX_CTRL_SEND_DATA.
- i_tx_ctrl_valid  in  1  request valid.
- o_tx_ctrl_ack  out  1  ready; a request is accepted when valid && ack.
- i_rcv_nxt  in  32  RCV.NXT, sampled as the ack number.
- i_iss_load  in  1  pulse: load SND.NXT from i_iss.
- i_iss  in  32  new initial sequence number.
- i_flush  in  1  pulse: discard all queued, not-yet-issued requests.
- o_seq_number  out  32  header sequence number.
- o_ack_number  out  32  header ack number.
- o_flags  out  8  TCP flags.
- o_window_size  out  16  header window.
- o_payload_len  out  LEN_W  payload length.
- o_hdr_valid  out  1  header fields valid.
- i_packet_done  in  1  builder finished the current segment.
- o_snd_nxt  out  32  current SND.NXT.
- o_busy  out  1  queue non-empty or segment in flight.

Behaviour:
- Reset values: all outputs 0, except o_snd_nxt = ISS and o_tx_ctrl_ack = 1. FIFO empty, state IDLE.
- o_tx_ctrl_ack = !fifo_full, combinational from FIFO state.
  - A push and a pop in the same cycle are legal.
  - When full, valid is ignored and no push occurs.
- States:
  - IDLE: if the FIFO is non-empty, pop one entry, register all header outputs, go to SEND.
  - SEND: o_hdr_valid = 1 and header outputs are held stable. On i_packet_done, advance SND.NXT, clear o_hdr_valid and all header outputs, go to IDLE.
- Latency: request accepted at cycle N → o_hdr_valid high at N+2 when IDLE with an empty queue. Back-to-back segments have one idle cycle between them.
- Flag and length mapping:
  - SEND_SYN → SYN, len 0.
  - SEND_SYN_ACK → SYN|ACK.
  - SEND_ACK → ACK.
  - SEND_FIN → FIN|ACK.
  - SEND_RST → RST|ACK.
  - SEND_DATA → PSH|ACK, o_payload_len = i_tx_len.
  - Any other encoding is popped and dropped with no header and no state change.
- o_seq_number = SND.NXT at pop. o_ack_number = i_rcv_nxt at pop if ACK is set, else 0.
- SND.NXT advance on i_packet_done = payload_len + SYN + FIN, modulo 2^32 (wraps from FFFF_FFFF). RST advances by 0.
- i_iss_load sets SND.NXT = i_iss next cycle and takes priority over a coincident done-advance. It does not alter an in-flight header's o_seq_number.
- i_flush empties the FIFO next cycle. It does not abort SEND. A push in the same cycle as a flush is discarded.
- i_packet_done in IDLE is ignored.
- Reset mid-SEND: o_hdr_valid drops next cycle, no SND.NXT advance, queue lost.

Optional Feature:
- Macro: TCP_TX_STATS_EN.
- Defined:
  - Adds o_seg_count[15:0], incremented on each i_packet_done in SEND.
  - Adds o_drop_count[7:0], incremented on each illegal encoding popped or on valid-while-full.
  - Both counters saturate and are cleared by reset.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- tcp_pkg holds:
  - tx_ctrl_t, extended with SEND_SYN_ACK, SEND_FIN, SEND_RST, SEND_DATA.
  - FLAG_FIN..FLAG_CWR constants.
  - tx_req_t struct {ctrl, len}.
- Sub-module tcp_tx_req_fifo: synchronous FIFO of tx_req_t, depth QUEUE_DEPTH, with full, empty and flush.

Test Plan:
- Reset, ISS=0x1000; SEND_SYN → hdr at N+2 with seq 0x1000, flags 0x02, ack 0. After done, o_snd_nxt = 0x1001.
- SEND_DATA len 100, i_rcv_nxt 0x5000, SND.NXT 0x1001 → seq 0x1001, ack 0x5000, flags 0x18, len 100. After done, SND.NXT = 0x1065.
- Push 5 requests while holding i_packet_done low, QUEUE_DEPTH 4 → 1 enters SEND, 4 queued, ack low on the 6th attempt. Each is then issued in order, one per done.
- i_iss_load 0xFFFF_FFFF, then SEND_FIN → seq FFFF_FFFF, flags 0x11. SND.NXT wraps to 0.
- SEND_RST → flags 0x14, SND.NXT unchanged. i_flush with 3 queued → o_busy drops after the in-flight segment completes.
- i_rst asserted mid-SEND → o_hdr_valid 0 next cycle, SND.NXT = ISS, o_tx_ctrl_ack 1.
